// File: rtl/board_reader.sv
// Row-major scanner of the occupied rectangle of the tile-grid RAM.
// Streams each cell's tile code with coordinates over valid/ready.
module board_reader #(
    parameter int depth   = 19,
    parameter int x_width = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [x_width:0]       min_x,
    input  logic [x_width:0]       min_y,
    input  logic [x_width:0]       max_x,
    input  logic [x_width:0]       max_y,
    output logic [depth+2:0]       ram_address,
    input  logic [3:0]             ram_data_read,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [3:0]             out_tile,
    output logic [x_width:0]       out_x,
    output logic [x_width:0]       out_y,
    output logic                   out_eol,
    output logic                   out_last,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [2*x_width+1:0]   tile_count
);

    localparam int AW = depth + 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_READ,
        S_OUT,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [x_width:0] r_min_x;
    logic [x_width:0] r_max_x;
    logic [x_width:0] r_max_y;
    logic [x_width:0] r_cur_x;
    logic [x_width:0] r_cur_y;
    logic             r_bad;

    logic          w_accept;
    logic          w_bad;
    logic          w_hs;
    logic          w_eol;
    logic [AW-1:0] w_addr;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_bad    = (min_x > max_x) || (min_y > max_y);
    assign w_hs     = (r_state == S_OUT) && out_ready;
    assign w_eol    = (r_cur_x == r_max_x);
    assign w_addr   = AW'({r_cur_y, r_cur_x});

    assign out_valid = (r_state == S_OUT);
    assign done      = (r_state == S_DONE);
    // Rejected bounds pass through ADDR once without ever reporting busy.
    assign busy      = !r_bad && ((r_state == S_ADDR) ||
                                  (r_state == S_READ) ||
                                  (r_state == S_OUT));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (start) w_next = S_ADDR;
            S_ADDR: w_next = r_bad ? S_DONE : S_READ;
            S_READ: w_next = S_OUT;
            S_OUT: begin
                if (out_ready) w_next = out_last ? S_DONE : S_ADDR;
            end
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_min_x     <= '0;
            r_max_x     <= '0;
            r_max_y     <= '0;
            r_cur_x     <= '0;
            r_cur_y     <= '0;
            r_bad       <= 1'b0;
            ram_address <= '0;
            out_tile    <= '0;
            out_x       <= '0;
            out_y       <= '0;
            out_eol     <= 1'b0;
            out_last    <= 1'b0;
            error       <= 1'b0;
            tile_count  <= '0;
        end else begin
            if (w_accept) begin
                r_min_x    <= min_x;
                r_max_x    <= max_x;
                r_max_y    <= max_y;
                r_cur_x    <= min_x;
                r_cur_y    <= min_y;
                r_bad      <= w_bad;
                error      <= w_bad;
                tile_count <= '0;
            end
            if ((r_state == S_ADDR) && !r_bad) begin
                ram_address <= w_addr;
            end
            if (r_state == S_READ) begin
                out_tile <= ram_data_read;
                out_x    <= r_cur_x;
                out_y    <= r_cur_y;
                out_eol  <= w_eol;
                out_last <= w_eol && (r_cur_y == r_max_y);
                if (ram_data_read > 4'd6) error <= 1'b1;
            end
            if (w_hs) begin
                if (out_tile != 4'd0) tile_count <= tile_count + 1'b1;
                if (!out_last) begin
                    if (w_eol) begin
                        r_cur_x <= r_min_x;
                        r_cur_y <= r_cur_y + 1'b1;
                    end else begin
                        r_cur_x <= r_cur_x + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: doc/board_reader.md
Name: board_reader

Overview:
- Read-side counterpart of the tile placer. Scans the occupied rectangle of the tile-grid RAM in row-major order and streams each cell's 4-bit tile code out through a valid/ready interface.
- Serves as the board source for display/serial dump and for the win-path checker.
- Uses the same RAM addressing as the placer: {y, x}, where x occupies ram_address[x_width:0] and y occupies ram_address[depth+2:x_width+1].

Parameters:
- depth, 19, RAM address width minus 3 (ram_address is depth+3 bits).
- x_width, 10, MSB index of x coordinate (x is x_width+1 bits).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle scan request; ignored unless idle.
- min_x  in  x_width+1  left column (placer offset_x).
- min_y  in  x_width+1  top row (placer offset_y).
- max_x  in  x_width+1  right column, inclusive (placer max_offset_x).
- max_y  in  x_width+1  bottom row, inclusive (placer max_offset_y).
- ram_address  out  depth+3  read address {y, x}.
- ram_data_read  in  4  tile code at ram_address.
- out_valid  out  1  stream word valid.
- out_ready  in  1  downstream accepts word.
- out_tile  out  4  tile code.
- out_x  out  x_width+1  column of out_tile.
- out_y  out  x_width+1  row of out_tile.
- out_eol  out  1  word is last column of its row.
- out_last  out  1  word is final cell of scan.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse at scan completion.
- error  out  1  sticky; cleared on accepted start.
- tile_count  out  2*x_width+2  nonzero cells emitted this scan.

Behaviour:
- Reset (async, reset=0): state IDLE; all outputs 0 (ram_address, out_*, busy, done, error, tile_count); internal cursor 0. Asserting reset mid-scan aborts immediately with no further output; out_valid drops asynchronously.
- start sampled only in IDLE. On acceptance:
  - latch min/max bounds; cursor = (min_x, min_y); error=0, tile_count=0.
  - if min_x>max_x or min_y>max_y: error=1, go to DONE (no words emitted).
  - otherwise go to ADDR; busy=1 from the next cycle.
- States:
  - IDLE: wait for start.
  - ADDR: ram_address={cur_y,cur_x} registered, held stable through READ.
  - READ: address unchanged; capture ram_data_read at end of cycle into out_tile; set out_x/out_y/out_eol/out_last; go to OUT.
  - OUT: out_valid=1; word fields held stable until out_ready=1 in the same cycle (handshake). On handshake:
    - if tile!=0, tile_count+1.
    - if out_last: go to DONE.
    - else advance cursor: x+1, or if x==max_x then x=min_x, y+1. Go to ADDR.
  - DONE: done=1 for exactly one cycle, busy=0, go to IDLE.
- Timing:
  - Latency from start edge to first out_valid: 3 cycles.
  - Throughput with out_ready held high: one word per 3 cycles.
  - Total scan time: 3·W·H+1 cycles, where W=max_x−min_x+1 and H=max_y−min_y+1.
- Flags:
  - out_eol = (cur_x==max_x).
  - out_last = out_eol && (cur_y==max_y).
- Tile codes: legal codes are 0..6. A code >6 sets error=1 (sticky) but the word is still emitted unchanged.
- Arithmetic: coordinates unsigned, modulo 2^(x_width+1); bounds compared unsigned. Cursor never exceeds max, so no wrap occurs within a legal scan.
- Bound inputs may change during a scan without effect, since they are latched at start.
- start asserted while busy or in DONE is ignored (not queued).
- out_ready asserted while out_valid=0 has no effect.
- ram write enable is not driven by this block; arbitration with the placer is external. The placer must be idle whenever busy=1.

Test Plan:
- 1x1 scan: bounds all 32, RAM(32,32)=3, out_ready=1. Required: out_valid 3 cycles after start; word tile=3, x=32, y=32, eol=1, last=1; done pulse next cycle; tile_count=1.
- 2x2 scan: x 32..33, y 32..33, RAM=3,0,5,6. Required: order (32,32),(33,32),(32,33),(33,33); eol on 2nd and 4th words, last on 4th; tile_count=3; done 13 cycles after start.
- Backpressure: same 2x2 scan with out_ready low for 5 cycles on word 2. Required: word 2 held stable during the stall; no RAM address change while in OUT; done 18 cycles after start.
- Bad bounds: min_x=40, max_x=33. Required: no out_valid; error=1; done pulse 2 cycles after start.
- Illegal code: RAM(32,32)=9 in a 1x1 scan. Required: word tile=9 emitted; error=1 after READ and still 1 after done; cleared by the next start.
- Reset mid-scan: pull reset low while in OUT of word 2, then release and issue start. Required: all outputs 0 immediately on reset; the new scan restarts at (min_x, min_y) with tile_count from 0; start pulsed while busy produces no second scan.
